// File: rtl/pipe_nodatahazards_if.sv
// Instruction-fetch stage for a hazard-free pipeline: PC register, next-PC select,
// IF/ID pipeline register, and stall/flush/misalignment bookkeeping.
module pipe_nodatahazards_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        IFwip,
  input  logic [1:0]  IDpcsrc,
  input  logic [31:0] IDbpc,
  input  logic [31:0] IDjpc,
  input  logic [31:0] IDrpc,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic [31:0] IFinst,
  output logic [31:0] IFpc4,
  output logic        IFvalid,
  output logic [15:0] IFstallCnt,
  output logic [15:0] IFflushCnt,
  output logic        IFmisalign
);

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JREG   = 2'b11;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        target_misaligned;

  assign imemAddr          = pc;
  assign pc_plus4          = pc + 32'd4;  // wraps naturally modulo 2^32
  assign redirect          = (IDpcsrc != PCSRC_SEQ);
  assign target_misaligned = (target[1:0] != 2'b00);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    target = pc_plus4;
    case (IDpcsrc)
      PCSRC_BRANCH: target = IDbpc;
      PCSRC_JUMP:   target = IDjpc;
      PCSRC_JREG:   target = IDrpc;
      default:      target = pc_plus4;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc         <= RESET_PC;
      IFinst     <= 32'h0;
      IFpc4      <= 32'h0;
      IFvalid    <= 1'b0;
      IFstallCnt <= 16'h0;
      IFflushCnt <= 16'h0;
      IFmisalign <= 1'b0;
    end else if (!IFwip) begin
      // Stall: pipeline state frozen, redirect requests are ignored.
      if (IFstallCnt != CNT_MAX) IFstallCnt <= IFstallCnt + 16'd1;
    end else if (redirect) begin
      // The word fetched this cycle is on the wrong path; inject a bubble.
      pc      <= {target[31:2], 2'b00};
      IFinst  <= 32'h0;
      IFpc4   <= 32'h0;
      IFvalid <= 1'b0;
      if (IFflushCnt != CNT_MAX) IFflushCnt <= IFflushCnt + 16'd1;
      if (target_misaligned)     IFmisalign <= 1'b1;
    end else begin
      pc      <= pc_plus4;
      IFinst  <= imemData;
      IFpc4   <= pc_plus4;
      IFvalid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_nodatahazards_if.sv
// Directed bench for the fetch stage: sequential fetch, stalls, redirects,
// misalignment, PC wrap, counter saturation and mid-run clear.
module tb_pipe_nodatahazards_if;

  logic        clk = 1'b0;
  logic        clr;
  logic        IFwip;
  logic [1:0]  IDpcsrc;
  logic [31:0] IDbpc, IDjpc, IDrpc;

  logic [31:0] imem_addr, imem_data, if_inst, if_pc4;
  logic        if_valid, if_misalign;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] w_addr, w_data, w_inst, w_pc4;
  logic        w_valid, w_misalign;
  logic [15:0] w_stall, w_flush;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] word_w(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign imem_data = word_at(imem_addr);
  assign w_data    = word_w(w_addr);

  pipe_nodatahazards_if dut (
    .clk(clk), .clr(clr), .IFwip(IFwip), .IDpcsrc(IDpcsrc),
    .IDbpc(IDbpc), .IDjpc(IDjpc), .IDrpc(IDrpc),
    .imemAddr(imem_addr), .imemData(imem_data),
    .IFinst(if_inst), .IFpc4(if_pc4), .IFvalid(if_valid),
    .IFstallCnt(stall_cnt), .IFflushCnt(flush_cnt), .IFmisalign(if_misalign)
  );

  pipe_nodatahazards_if #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .clr(clr), .IFwip(IFwip), .IDpcsrc(IDpcsrc),
    .IDbpc(IDbpc), .IDjpc(IDjpc), .IDrpc(IDrpc),
    .imemAddr(w_addr), .imemData(w_data),
    .IFinst(w_inst), .IFpc4(w_pc4), .IFvalid(w_valid),
    .IFstallCnt(w_stall), .IFflushCnt(w_flush), .IFmisalign(w_misalign)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic valid, input logic [15:0] stalls,
                             input logic [15:0] flushes, input logic mis);
    check({tag, ".addr"},     imem_addr,   addr);
    check({tag, ".inst"},     if_inst,     inst);
    check({tag, ".pc4"},      if_pc4,      pc4);
    check({tag, ".valid"},    {31'b0, if_valid},    {31'b0, valid});
    check({tag, ".stall"},    {16'b0, stall_cnt},   {16'b0, stalls});
    check({tag, ".flush"},    {16'b0, flush_cnt},   {16'b0, flushes});
    check({tag, ".misalign"}, {31'b0, if_misalign}, {31'b0, mis});
  endtask

  initial begin
    clr = 1'b1; IFwip = 1'b1; IDpcsrc = 2'b00;
    IDbpc = 32'h0; IDjpc = 32'h0; IDrpc = 32'h0;
    #2;

    // Reset
    step();
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
    check("wrap.reset_addr", w_addr, 32'hFFFF_FFFC);
    clr = 1'b0;

    // Sequential fetch; the wrap instance crosses 2^32 on the same edge
    step();
    check_state("seq0", 32'h4, word_at(32'h0), 32'h4, 1'b1, 16'd0, 16'd0, 1'b0);
    check("wrap.addr", w_addr, 32'h0);
    check("wrap.inst", w_inst, word_w(32'hFFFF_FFFC));
    check("wrap.pc4",  w_pc4,  32'h0);
    step();
    check_state("seq1", 32'h8, word_at(32'h4), 32'h8, 1'b1, 16'd0, 16'd0, 1'b0);

    // Stall three cycles at PC=8 while a jump is requested
    IFwip = 1'b0; IDpcsrc = 2'b10; IDjpc = 32'h100;
    step();
    check_state("stall1", 32'h8, word_at(32'h4), 32'h8, 1'b1, 16'd1, 16'd0, 1'b0);
    step();
    check_state("stall2", 32'h8, word_at(32'h4), 32'h8, 1'b1, 16'd2, 16'd0, 1'b0);
    step();
    check_state("stall3", 32'h8, word_at(32'h4), 32'h8, 1'b1, 16'd3, 16'd0, 1'b0);

    IFwip = 1'b1; IDpcsrc = 2'b00;
    step();
    check_state("seq2", 32'hC, word_at(32'h8), 32'hC, 1'b1, 16'd3, 16'd0, 1'b0);

    // Stall over redirect, then release with the jump still asserted
    IFwip = 1'b0; IDpcsrc = 2'b10;
    step();
    check_state("stall_jump", 32'hC, word_at(32'h8), 32'hC, 1'b1, 16'd4, 16'd0, 1'b0);
    IFwip = 1'b1;
    step();
    check_state("jump", 32'h100, 32'h0, 32'h0, 1'b0, 16'd4, 16'd1, 1'b0);

    IDpcsrc = 2'b00;
    step();
    check_state("after_jump", 32'h104, word_at(32'h100), 32'h104, 1'b1, 16'd4, 16'd1, 1'b0);

    // Misaligned branch
    IDpcsrc = 2'b01; IDbpc = 32'h0000_0042;
    step();
    check_state("branch", 32'h40, 32'h0, 32'h0, 1'b0, 16'd4, 16'd2, 1'b1);
    IDpcsrc = 2'b00;
    repeat (10) step();
    check_state("sticky", 32'h68, word_at(32'h64), 32'h68, 1'b1, 16'd4, 16'd2, 1'b1);

    // Jump-register must pick IDrpc, not the other targets
    IDpcsrc = 2'b11; IDbpc = 32'h300; IDjpc = 32'h400; IDrpc = 32'h200;
    step();
    check_state("jreg", 32'h200, 32'h0, 32'h0, 1'b0, 16'd4, 16'd3, 1'b1);
    IDpcsrc = 2'b00;
    step();
    check_state("after_jreg", 32'h204, word_at(32'h200), 32'h204, 1'b1, 16'd4, 16'd3, 1'b1);

    // Mid-run clear during a redirect, then during a stall
    clr = 1'b1; IDpcsrc = 2'b10; IDjpc = 32'h503;
    step();
    check_state("clr_redirect", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
    IFwip = 1'b0;
    step();
    check_state("clr_stall", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
    clr = 1'b0; IFwip = 1'b1; IDpcsrc = 2'b00;
    step();
    check_state("first_fetch", 32'h4, word_at(32'h0), 32'h4, 1'b1, 16'd0, 16'd0, 1'b0);

    // Stall counter saturation
    IFwip = 1'b0; IDpcsrc = 2'b01; IDbpc = 32'h80;
    repeat (65534) @(posedge clk);
    #1;
    check("stall.65534", {16'b0, stall_cnt}, 32'h0000_FFFE);
    step();
    check("stall.max", {16'b0, stall_cnt}, 32'h0000_FFFF);
    repeat (4465) @(posedge clk);
    #1;
    check_state("stall.sat", 32'h4, word_at(32'h0), 32'h4, 1'b1, 16'hFFFF, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
